// File: rtl/sbox_pkg.sv
// sbox_pkg: shared FSM state type, block geometry and forward AES S-box lookup.
// The inverse lookup exists only when `SBOX_FWD_SERIAL_INV_SEL_EN is defined.
package sbox_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int NUM_BYTES = 16;

    // FIPS-197 forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Width of the step counter; at least 1 bit even when one step covers the block.
    function automatic int cnt_width(input int bpc);
        return (NUM_BYTES / bpc > 1) ? $clog2(NUM_BYTES / bpc) : 1;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return SBOX_FWD_TBL[{~x, 3'b000} +: 8];
    endfunction

`ifdef SBOX_FWD_SERIAL_INV_SEL_EN
    // Inverse derived from the forward table so the two can never disagree.
    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 256; i++) begin
            if (sbox_fwd(8'(i)) == x) r = 8'(i);
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/sbox_fwd_serial_sbox.sv
// S_Sbox: 8-bit forward AES S-box. S_Inv_Sbox (inverse) is built only with
// `SBOX_FWD_SERIAL_INV_SEL_EN defined.
module S_Sbox
    import sbox_pkg::*;
(
    input  logic [7:0] in,
    output logic [7:0] out
);
    assign out = sbox_fwd(in);
endmodule

`ifdef SBOX_FWD_SERIAL_INV_SEL_EN
module S_Inv_Sbox
    import sbox_pkg::*;
(
    input  logic [7:0] in,
    output logic [7:0] out
);
    assign out = sbox_inv(in);
endmodule
`endif

// File: rtl/sbox_fwd_serial.sv
// sbox_fwd_serial: serialised AES SubBytes over a 128-bit block, BYTES_PER_CYCLE lanes.
// Define `SBOX_FWD_SERIAL_INV_SEL_EN to add port inv selecting the inverse S-box per block.
module sbox_fwd_serial
    import sbox_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] in,
    input  logic         in_valid,
    output logic         in_ready,
`ifdef SBOX_FWD_SERIAL_INV_SEL_EN
    input  logic         inv,
`endif
    output logic [127:0] out,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int CW    = cnt_width(BYTES_PER_CYCLE);
    localparam int STEPS = NUM_BYTES / BYTES_PER_CYCLE;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [127:0]  r_data;
    logic [7:0]    w_lane_in  [BYTES_PER_CYCLE];
    logic [7:0]    w_lane_out [BYTES_PER_CYCLE];
`ifdef SBOX_FWD_SERIAL_INV_SEL_EN
    logic          r_inv;
`endif

    // LSB position of the byte handled by a lane at a given step; byte 0 sits at [127:120].
    function automatic logic [6:0] byte_lsb(input logic [CW-1:0] cnt, input int lane);
        return 7'((NUM_BYTES - 1 - (int'(cnt) * BYTES_PER_CYCLE + lane)) * 8);
    endfunction

    always_comb begin
        for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
            w_lane_in[j] = r_data[byte_lsb(r_cnt, int'(j)) +: 8];
        end
    end

    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
        logic [7:0] w_fwd;
        S_Sbox u_fwd (.in(w_lane_in[j]), .out(w_fwd));
`ifdef SBOX_FWD_SERIAL_INV_SEL_EN
        logic [7:0] w_inv;
        S_Inv_Sbox u_inv (.in(w_lane_in[j]), .out(w_inv));
        assign w_lane_out[j] = r_inv ? w_inv : w_fwd;
`else
        assign w_lane_out[j] = w_fwd;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
`ifdef SBOX_FWD_SERIAL_INV_SEL_EN
            r_inv   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data <= in;
                        r_cnt  <= '0;
`ifdef SBOX_FWD_SERIAL_INV_SEL_EN
                        r_inv  <= inv;
`endif
                    end
                end
                BUSY: begin
                    // Substitution is done in place, so out shows partial results while busy.
                    for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
                        r_data[byte_lsb(r_cnt, int'(j)) +: 8] <= w_lane_out[j];
                    end
                    if (r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (r_cnt == LAST) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign out = r_data;

endmodule
